// File: rtl/mem_stage_if.sv
// EXE/MEM -> MEM stage -> MEM/WB signal bundle.
// master: upstream side (drives the EXE/MEM fields, observes freeze and MEM/WB outputs).
// slave:  the memory stage itself.
interface mem_stage_if;
  // EXE/MEM register outputs
  logic [31:0] PC_in;
  logic [31:0] ALU_result_in;
  logic [31:0] ST_val_in;
  logic [4:0]  Dest_in;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  // Stall request to upstream
  logic        freeze;
  // MEM/WB register outputs
  logic [31:0] PC;
  logic [31:0] ALU_result;
  logic [31:0] MEM_read_value;
  logic [4:0]  Dest;
  logic        WB_EN;
  logic        MEM_R_EN;

  modport master (
    output PC_in, ALU_result_in, ST_val_in, Dest_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
    input  freeze, PC, ALU_result, MEM_read_value, Dest, WB_EN, MEM_R_EN
  );

  modport slave (
    input  PC_in, ALU_result_in, ST_val_in, Dest_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
    output freeze, PC, ALU_result, MEM_read_value, Dest, WB_EN, MEM_R_EN
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data RAM, optional wait states, MEM/WB register.
// Define MEM_WAIT_STATES_EN to compile in the wait-state FSM; otherwise every access
// completes in the cycle it is presented and freeze is tied low.
module mem_stage #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          access;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   ld_val;
  logic          freeze;
  logic [1:0]    unused_off;

  assign access     = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  assign off        = bus.ALU_result_in - 32'(BASE_ADDR);
  assign idx        = off[AW+1:2];
  assign unused_off = off[1:0];
  assign in_range   = off[31:2] < 30'(DEPTH);
  assign ld_val     = (bus.MEM_R_EN_in && in_range) ? mem[idx] : 32'd0;
  assign bus.freeze = freeze;

`ifdef MEM_WAIT_STATES_EN
  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] WaitM1 = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;

  // Stall while an access is still counting down its wait states.
  always_comb begin
    freeze = 1'b0;
    if (!rst && WAIT_CYCLES != 0) begin
      case (state_q)
        StIdle:  freeze = access;
        StBusy:  freeze = (cnt_q != 4'd0);
        default: freeze = 1'b0;
      endcase
    end
  end

  // Wait-state sequencer; reset mid-access drops back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access && WAIT_CYCLES != 0) begin
            state_q <= StBusy;
            cnt_q   <= WaitM1;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else               state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  localparam int unsigned unused_wait = WAIT_CYCLES;

  // Single-cycle build: never stall.
  always_comb freeze = 1'b0;
`endif

  // Data RAM write at the completion edge; not cleared by reset, writes aborted by it.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && bus.MEM_W_EN_in && in_range) mem[idx] <= bus.ST_val_in;
  end

  // MEM/WB register; a stall cycle loads a bubble (write-back and load flags cleared).
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.PC             <= 32'd0;
      bus.ALU_result     <= 32'd0;
      bus.MEM_read_value <= 32'd0;
      bus.Dest           <= 5'd0;
      bus.WB_EN          <= 1'b0;
      bus.MEM_R_EN       <= 1'b0;
    end else begin
      bus.PC             <= bus.PC_in;
      bus.ALU_result     <= bus.ALU_result_in;
      bus.MEM_read_value <= ld_val;
      bus.Dest           <= bus.Dest_in;
      bus.WB_EN          <= bus.WB_EN_in & ~freeze;
      bus.MEM_R_EN       <= bus.MEM_R_EN_in & ~freeze;
    end
  end

endmodule
